// File: rtl/multdiv_sequencer.sv
// Sequencer for the shared iterative multiply/divide unit: decodes mul/div,
// stalls the front end while the unit iterates and issues one writeback.
module multdiv_sequencer #(
  parameter int CYCLES = 32,
  parameter int WIDTH  = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             issueValid,
  input  logic [4:0]       opCode,
  input  logic [4:0]       aluOp,
  input  logic [4:0]       rdIn,
  input  logic [WIDTH-1:0] operandB,
  input  logic             flush,
  input  logic [WIDTH-1:0] unitResult,
  input  logic             unitOverflow,
  output logic             stall,
  output logic             unitStart,
  output logic             unitIsDiv,
  output logic             busy,
  output logic             wbValid,
  output logic [4:0]       wbReg,
  output logic [WIDTH-1:0] wbData,
  output logic             exception
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT         stateReg, stateNext;
  logic [CW-1:0] countReg, countNext;
  logic [4:0]    rdReg, rdNext;
  logic          isDivReg, isDivNext;
  logic          divZeroReg, divZeroNext;
  logic          firstReg, firstNext;

  logic isMul, isDiv, isMD, accept, divZeroIn, inDone, mulOverflow;

  assign isMul     = (opCode == 5'b00000) && (aluOp == 5'b00110);
  assign isDiv     = (opCode == 5'b00000) && (aluOp == 5'b00111);
  assign isMD      = isMul || isDiv;
  assign accept    = (stateReg == IDLE) && issueValid && isMD && !flush;
  assign divZeroIn = isDiv && (operandB == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stateReg   <= IDLE;
      countReg   <= '0;
      rdReg      <= '0;
      isDivReg   <= 1'b0;
      divZeroReg <= 1'b0;
      firstReg   <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      countReg   <= countNext;
      rdReg      <= rdNext;
      isDivReg   <= isDivNext;
      divZeroReg <= divZeroNext;
      firstReg   <= firstNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    countNext   = countReg;
    rdNext      = rdReg;
    isDivNext   = isDivReg;
    divZeroNext = divZeroReg;
    firstNext   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          rdNext      = rdIn;
          isDivNext   = isDiv;
          divZeroNext = divZeroIn;
          // Divide-by-zero never starts the unit; report straight away.
          if (divZeroIn) begin
            stateNext = DONE;
          end else begin
            countNext = CW'(CYCLES - 1);
            firstNext = 1'b1;
            stateNext = RUN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          stateNext = IDLE;
        end else if (countReg == '0) begin
          stateNext = DONE;
        end else begin
          countNext = countReg - 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign inDone      = (stateReg == DONE);
  assign mulOverflow = !isDivReg && unitOverflow;

  assign busy      = (stateReg != IDLE);
  assign unitStart = firstReg && (stateReg == RUN);
  assign unitIsDiv = isDivReg && busy;
  // The accept term is combinational so the front end freezes in the issue cycle.
  assign stall     = resetn && (accept || (stateReg == RUN));
  assign wbValid   = inDone && !flush;
  assign exception = inDone && (divZeroReg || mulOverflow);

  always_comb begin
    wbReg  = '0;
    wbData = '0;
    if (inDone) begin
      if (divZeroReg) begin
        wbReg  = 5'd30;
        wbData = WIDTH'(5);
      end else if (mulOverflow) begin
        wbReg  = 5'd30;
        wbData = WIDTH'(4);
      end else begin
        wbReg  = rdReg;
        wbData = unitResult;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: vector table plus hand sequences,
// writebacks checked against a scoreboard queue.
module tb_multdiv_sequencer;

  localparam int CYCLES = 32;
  localparam int WIDTH  = 32;

  logic             clock = 1'b0;
  logic             resetn;
  logic             issueValid;
  logic [4:0]       opCode, aluOp, rdIn;
  logic [WIDTH-1:0] operandB;
  logic             flush;
  logic [WIDTH-1:0] unitResult;
  logic             unitOverflow;
  logic             stall, unitStart, unitIsDiv, busy, wbValid, exception;
  logic [4:0]       wbReg;
  logic [WIDTH-1:0] wbData;

  multdiv_sequencer #(.CYCLES(CYCLES), .WIDTH(WIDTH)) dut (
    .clock(clock), .resetn(resetn), .issueValid(issueValid), .opCode(opCode),
    .aluOp(aluOp), .rdIn(rdIn), .operandB(operandB), .flush(flush),
    .unitResult(unitResult), .unitOverflow(unitOverflow), .stall(stall),
    .unitStart(unitStart), .unitIsDiv(unitIsDiv), .busy(busy), .wbValid(wbValid),
    .wbReg(wbReg), .wbData(wbData), .exception(exception)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic        e;
  } expT;

  typedef struct {
    logic [4:0]  op, alu, rd;
    logic [31:0] opB, res;
    logic        ovf, fl, acc;
    logic [4:0]  eReg;
    logic [31:0] eData;
    logic        eExc;
    int          eLat;
  } vecT;

  expT sb[$];
  int  passCount = 0;
  int  checkCount = 0;
  vecT vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Writeback monitor: every wbValid must match the oldest expected entry.
  always @(negedge clock) begin : monitor
    expT e;
    if (wbValid === 1'b1) begin
      $display("wb rd=%0d data=%h exc=%0b", wbReg, wbData, exception);
      if (sb.size() == 0) begin
        checkCount++;
        $display("FAIL unexpected_wb: got wbReg=%0d wbData=%h, required no writeback", wbReg, wbData);
      end else begin
        e = sb.pop_front();
        chk("wb_reg", wbReg, e.r);
        chk("wb_data", wbData, e.d);
        chk("wb_exception", exception, e.e);
      end
    end
  end

  task automatic issue(input logic [4:0] alu, input logic [4:0] rd, input logic [31:0] b, input logic fl);
    @(posedge clock); #1;
    issueValid = 1'b1; opCode = 5'b00000; aluOp = alu; rdIn = rd; operandB = b; flush = fl;
  endtask

  task automatic runVec(input vecT v);
    int stallCnt, startCnt, wbCyc;
    unitResult = v.res; unitOverflow = v.ovf;
    @(posedge clock); #1;
    issueValid = 1'b1; opCode = v.op; aluOp = v.alu; rdIn = v.rd; operandB = v.opB; flush = v.fl;
    @(negedge clock);
    chk("stall_c0", stall, v.acc);
    stallCnt = (stall === 1'b1) ? 1 : 0;
    startCnt = 0;
    wbCyc = 0;
    if (v.acc) sb.push_back('{v.eReg, v.eData, v.eExc});
    @(posedge clock); #1;
    issueValid = 1'b0; flush = 1'b0;
    if (v.acc) begin
      for (int c = 1; c <= CYCLES + 10 && wbCyc == 0; c++) begin
        @(negedge clock);
        if (c == 1) begin
          chk("unitStart_c1", unitStart, v.eLat > 1);
          if (v.eLat > 1) chk("unitIsDiv_c1", unitIsDiv, v.alu == 5'b00111);
        end
        if (unitStart === 1'b1) startCnt++;
        if (stall === 1'b1) stallCnt++;
        if (wbValid === 1'b1) wbCyc = c;
      end
      chk("wb_latency", wbCyc, v.eLat);
      chk("stall_cycles", stallCnt, v.eLat);
      chk("start_pulses", startCnt, v.eLat > 1);
      @(negedge clock);
      chk("busy_after_wb", busy, 1'b0);
    end else begin
      repeat (3) @(negedge clock);
      chk("not_accepted_busy", busy, 1'b0);
    end
  endtask

  initial begin
    int wbCyc;
    resetn = 1'b0; issueValid = 1'b0; opCode = '0; aluOp = '0; rdIn = '0;
    operandB = '0; flush = 1'b0; unitResult = '0; unitOverflow = 1'b0;

    //         op     alu       rd     opB            res            ovf  fl   acc  eReg   eData          eExc lat
    vecs[0] = '{5'd0, 5'b00110, 5'd5,  32'd3,         32'h00000048, 1'b0,1'b0,1'b1,5'd5,  32'h00000048, 1'b0, CYCLES+1};
    vecs[1] = '{5'd0, 5'b00111, 5'd7,  32'd0,         32'h12345678, 1'b0,1'b0,1'b1,5'd30, 32'd5,        1'b1, 1};
    vecs[2] = '{5'd0, 5'b00110, 5'd3,  32'd11,        32'h00001234, 1'b1,1'b0,1'b1,5'd30, 32'd4,        1'b1, CYCLES+1};
    vecs[3] = '{5'd0, 5'b00111, 5'd3,  32'd9,         32'h00000055, 1'b1,1'b0,1'b1,5'd3,  32'h00000055, 1'b0, CYCLES+1};
    vecs[4] = '{5'd0, 5'b00000, 5'd4,  32'd1,         32'h00000001, 1'b0,1'b0,1'b0,5'd0,  32'd0,        1'b0, 0};
    vecs[5] = '{5'd1, 5'b00110, 5'd4,  32'd1,         32'h00000001, 1'b0,1'b0,1'b0,5'd0,  32'd0,        1'b0, 0};
    vecs[6] = '{5'd0, 5'b00110, 5'd12, 32'd0,         32'h00000000, 1'b0,1'b0,1'b1,5'd12, 32'h00000000, 1'b0, CYCLES+1};
    vecs[7] = '{5'd0, 5'b00111, 5'd31, 32'd1,         32'hFFFFFFFF, 1'b0,1'b0,1'b1,5'd31, 32'hFFFFFFFF, 1'b0, CYCLES+1};
    vecs[8] = '{5'd0, 5'b00110, 5'd6,  32'd2,         32'h00000010, 1'b0,1'b1,1'b0,5'd0,  32'd0,        1'b0, 0};

    // Reset state, with a mul presented so stall must be held low by reset.
    #2;
    issueValid = 1'b1; aluOp = 5'b00110; rdIn = 5'd9; operandB = 32'd2;
    #1;
    chk("reset_stall", stall, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_wbValid", wbValid, 1'b0);
    chk("reset_wbReg", wbReg, 5'd0);
    chk("reset_wbData", wbData, 32'd0);
    chk("reset_unitStart", unitStart, 1'b0);
    chk("reset_unitIsDiv", unitIsDiv, 1'b0);
    chk("reset_exception", exception, 1'b0);
    issueValid = 1'b0; aluOp = '0;
    @(negedge clock);
    resetn = 1'b1;

    foreach (vecs[i]) runVec(vecs[i]);

    // Flush in RUN cycle 10: back to IDLE in cycle 11, no writeback ever.
    unitResult = 32'hDEAD0001; unitOverflow = 1'b0;
    issue(5'b00111, 5'd8, 32'd4, 1'b0);
    @(posedge clock); #1 issueValid = 1'b0;
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(negedge clock);
    chk("flushrun_c10_busy", busy, 1'b1);
    chk("flushrun_c10_wbValid", wbValid, 1'b0);
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    chk("flushrun_c11_busy", busy, 1'b0);
    chk("flushrun_c11_stall", stall, 1'b0);
    repeat (CYCLES + 5) @(negedge clock);

    // Flush during DONE suppresses the writeback.
    issue(5'b00110, 5'd14, 32'd3, 1'b0);
    @(posedge clock); #1 issueValid = 1'b0;
    repeat (CYCLES) @(posedge clock);
    #1 flush = 1'b1;
    @(negedge clock);
    chk("flushdone_busy", busy, 1'b1);
    chk("flushdone_wbValid", wbValid, 1'b0);
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    chk("flushdone_after_busy", busy, 1'b0);

    // Asynchronous reset in RUN cycle 15 discards the operation.
    unitResult = 32'hCAFE0002;
    issue(5'b00110, 5'd6, 32'd3, 1'b0);
    @(posedge clock); #1 issueValid = 1'b0;
    repeat (14) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("midrun_reset_busy", busy, 1'b0);
    chk("midrun_reset_stall", stall, 1'b0);
    chk("midrun_reset_unitIsDiv", unitIsDiv, 1'b0);
    chk("midrun_reset_wbData", wbData, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (CYCLES + 5) @(negedge clock);
    chk("midrun_reset_idle", busy, 1'b0);

    // Back-to-back: second mul presented in DONE is accepted one cycle later.
    unitResult = 32'h00000077; unitOverflow = 1'b0;
    issue(5'b00110, 5'd9, 32'd5, 1'b0);
    sb.push_back('{5'd9, 32'h00000077, 1'b0});
    @(posedge clock); #1 issueValid = 1'b0;
    repeat (CYCLES) @(posedge clock);
    #1 issueValid = 1'b1; rdIn = 5'd10;
    @(negedge clock);
    chk("b2b_done_wbValid", wbValid, 1'b1);
    chk("b2b_done_stall", stall, 1'b0);
    @(negedge clock);
    chk("b2b_accept_stall", stall, 1'b1);
    sb.push_back('{5'd10, 32'h00000099, 1'b0});
    @(posedge clock); #1 issueValid = 1'b0; unitResult = 32'h00000099;
    wbCyc = 0;
    for (int c = 1; c <= CYCLES + 10 && wbCyc == 0; c++) begin
      @(negedge clock);
      if (wbValid === 1'b1) wbCyc = c;
    end
    chk("b2b_second_latency", wbCyc, CYCLES + 1);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
